// File: rtl/br_predictor.sv
// br_predictor: BTB with 2-bit saturating counters for the RV32I fetch stage.
// Optional global-history (gshare) indexing is enabled by defining BR_PRED_GSHARE_EN.
// Lookups are combinational and training happens at the clock edge. Mispredict
// and redirect are computed combinationally from the EX update inputs.
module br_predictor #(
   parameter int IDX_W = 6,
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [31:0]      i_if_pc,
   output logic             o_pred_taken,
   output logic [31:0]      o_pred_target,
   output logic [IDX_W-1:0] o_pred_ghr,
   input  logic             i_upd_vld,
   input  logic [31:0]      i_upd_pc,
   input  logic             i_upd_taken,
   input  logic [31:0]      i_upd_target,
   input  logic             i_upd_pred_taken,
   input  logic [31:0]      i_upd_pred_target,
   input  logic [IDX_W-1:0] i_upd_ghr,
   output logic             o_mispred,
   output logic [31:0]      o_redirect_pc,
   output logic [CNT_W-1:0] o_br_cnt,
   output logic [CNT_W-1:0] o_mispred_cnt
);

   localparam int unsigned ENTRIES = 1 << IDX_W;
   localparam int          TAG_W   = 30 - IDX_W;

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];

   logic [IDX_W-1:0] ghr;
   logic [IDX_W-1:0] upd_hist;
   logic [IDX_W-1:0] lk_idx;
   logic             lk_hit;
   logic [IDX_W-1:0] upd_idx;
   logic             upd_hit;
   logic             wr_en;
   logic [31:0]      wr_target;
   logic [1:0]       wr_ctr;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
   logic             unused_bits;

   // Low PC bits are always zero for word-aligned fetch; history input is
   // ignored entirely in the PC-only build.
   assign unused_bits = ^{i_if_pc[1:0], i_upd_ghr};

`ifdef BR_PRED_GSHARE_EN
   logic [IDX_W-1:0] ghr_q, ghr_d;

   assign ghr      = ghr_q;
   assign upd_hist = i_upd_ghr;

   // Shift the resolved direction into the global history on every update
   always_comb begin
      ghr_d = ghr_q;
      if (i_upd_vld) ghr_d = {ghr_q[IDX_W-2:0], i_upd_taken};
   end

   // Global history register
   always_ff @(posedge i_clk) begin
      if (i_rst) ghr_q <= '0;
      else       ghr_q <= ghr_d;
   end
`else
   assign ghr      = '0;
   assign upd_hist = '0;
`endif

   assign lk_idx  = i_if_pc[IDX_W+1:2] ^ ghr;
   assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == i_if_pc[31:IDX_W+2]);
   assign upd_idx = i_upd_pc[IDX_W+1:2] ^ upd_hist;
   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == i_upd_pc[31:IDX_W+2]);

   assign o_pred_taken  = lk_hit & ctr_q[lk_idx][1];
   assign o_pred_target = target_q[lk_idx];
   assign o_pred_ghr    = ghr;

   assign o_mispred = i_upd_vld & ((i_upd_taken ^ i_upd_pred_taken) |
                                   (i_upd_taken & (i_upd_target != i_upd_pred_target)));
   assign o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;

   // Training decision: counter/target for the indexed entry, or no write
   always_comb begin
      wr_en     = 1'b0;
      wr_target = target_q[upd_idx];
      wr_ctr    = ctr_q[upd_idx];
      if (i_upd_vld) begin
         if (upd_hit) begin
            wr_en = 1'b1;
            if (i_upd_taken) begin
               wr_target = i_upd_target;
               if (ctr_q[upd_idx] != 2'b11) wr_ctr = ctr_q[upd_idx] + 2'd1;
            end else begin
               if (ctr_q[upd_idx] != 2'b00) wr_ctr = ctr_q[upd_idx] - 2'd1;
            end
         end else if (i_upd_taken) begin
            wr_en     = 1'b1;
            wr_target = i_upd_target;
            wr_ctr    = 2'b10;
         end
      end
   end

   // BTB storage: cleared on reset, single-entry write per update
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (wr_en) begin
         valid_q[upd_idx]  <= 1'b1;
         tag_q[upd_idx]    <= i_upd_pc[31:IDX_W+2];
         target_q[upd_idx] <= wr_target;
         ctr_q[upd_idx]    <= wr_ctr;
      end
   end

   // Saturating performance counter next-state
   always_comb begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (i_upd_vld && (br_cnt_q != '1)) br_cnt_d  = br_cnt_q + CNT_W'(1);
      if (o_mispred && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
   end

   // Performance counter registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else begin
         br_cnt_q  <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end

   assign o_br_cnt      = br_cnt_q;
   assign o_mispred_cnt = mis_cnt_q;

endmodule

// File: tb/tb_br_predictor.sv
// Self-checking bench for br_predictor (IDX_W=6, CNT_W=4). Directed scenarios
// plus randomized traffic compared against a behavioural table model.
// Honours BR_PRED_GSHARE_EN the same way the design does.
`timescale 1ns/1ps
module tb_br_predictor;
   localparam int IDX_W = 6;
   localparam int CNT_W = 4;
   localparam int NENT  = 64;
   localparam int CMAX  = 15;
`ifdef BR_PRED_GSHARE_EN
   localparam bit GS = 1'b1;
`else
   localparam bit GS = 1'b0;
`endif

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic [31:0]      i_if_pc;
   logic             o_pred_taken;
   logic [31:0]      o_pred_target;
   logic [IDX_W-1:0] o_pred_ghr;
   logic             i_upd_vld;
   logic [31:0]      i_upd_pc;
   logic             i_upd_taken;
   logic [31:0]      i_upd_target;
   logic             i_upd_pred_taken;
   logic [31:0]      i_upd_pred_target;
   logic [IDX_W-1:0] i_upd_ghr;
   logic             o_mispred;
   logic [31:0]      o_redirect_pc;
   logic [CNT_W-1:0] o_br_cnt;
   logic [CNT_W-1:0] o_mispred_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit          m_valid [NENT];
   logic [31:0] m_tag   [NENT];
   logic [31:0] m_tgt   [NENT];
   int          m_ctr   [NENT];
   int          m_ghr;
   int          m_br;
   int          m_mis;

   br_predictor #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .i_clk             (i_clk),
      .i_rst             (i_rst),
      .i_if_pc           (i_if_pc),
      .o_pred_taken      (o_pred_taken),
      .o_pred_target     (o_pred_target),
      .o_pred_ghr        (o_pred_ghr),
      .i_upd_vld         (i_upd_vld),
      .i_upd_pc          (i_upd_pc),
      .i_upd_taken       (i_upd_taken),
      .i_upd_target      (i_upd_target),
      .i_upd_pred_taken  (i_upd_pred_taken),
      .i_upd_pred_target (i_upd_pred_target),
      .i_upd_ghr         (i_upd_ghr),
      .o_mispred         (o_mispred),
      .o_redirect_pc     (o_redirect_pc),
      .o_br_cnt          (o_br_cnt),
      .o_mispred_cnt     (o_mispred_cnt)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic int m_idx(input logic [31:0] pc, input int h);
      int i;
      i = int'((pc >> 2) % 64);
      return GS ? (i ^ h) : i;
   endfunction

   function automatic bit m_pred_taken(input logic [31:0] pc);
      int i;
      i = m_idx(pc, m_ghr);
      return m_valid[i] && (m_tag[i] == (pc >> 8)) && (m_ctr[i] >= 2);
   endfunction

   function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
      return m_tgt[m_idx(pc, m_ghr)];
   endfunction

   function automatic bit m_mispred();
      if (!i_upd_vld) return 1'b0;
      if (i_upd_taken != i_upd_pred_taken) return 1'b1;
      return i_upd_taken && (i_upd_target != i_upd_pred_target);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NENT; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_tgt[i]   = '0;
         m_ctr[i]   = 1;
      end
      m_ghr = 0;
      m_br  = 0;
      m_mis = 0;
   endtask

   task automatic m_commit();
      int  i;
      bit  hit;
      bit  mis;
      mis = m_mispred();
      i   = m_idx(i_upd_pc, int'(i_upd_ghr));
      hit = m_valid[i] && (m_tag[i] == (i_upd_pc >> 8));
      if (hit) begin
         if (i_upd_taken) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = i_upd_target;
         end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
         end
      end else if (i_upd_taken) begin
         m_valid[i] = 1'b1;
         m_tag[i]   = i_upd_pc >> 8;
         m_tgt[i]   = i_upd_target;
         m_ctr[i]   = 2;
      end
      if (GS) m_ghr = ((m_ghr << 1) | int'(i_upd_taken)) % NENT;
      m_br = (m_br < CMAX) ? m_br + 1 : CMAX;
      if (mis) m_mis = (m_mis < CMAX) ? m_mis + 1 : CMAX;
   endtask

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic apply_reset();
      @(negedge i_clk);
      i_rst     = 1'b1;
      i_upd_vld = 1'b0;
      repeat (2) @(posedge i_clk);
      m_reset();
      #1;
      i_rst = 1'b0;
   endtask

   task automatic upd_begin(input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                            input bit ptk, input logic [31:0] ptg, input int gh);
      @(negedge i_clk);
      i_upd_pc          = pc;
      i_upd_taken       = tk;
      i_upd_target      = tg;
      i_upd_pred_taken  = ptk;
      i_upd_pred_target = ptg;
      i_upd_ghr         = IDX_W'(gh);
      i_upd_vld         = 1'b1;
      #1;
   endtask

   task automatic upd_end();
      @(posedge i_clk);
      if (i_rst) m_reset();
      else       m_commit();
      #1;
      i_upd_vld = 1'b0;
   endtask

   task automatic look(input logic [31:0] pc);
      i_if_pc = pc;
      #1;
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] p;
      if ($urandom_range(0, 7) == 0) p = $urandom() & 32'hFFFF_FFFC;
      else p = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
      return p;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
      look(32'h0000_0040);
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL rst_taken got %0b want 0", o_pred_taken); end
      checks++; if (o_pred_target !== 32'h0) begin errors++; $display("FAIL rst_target got %h want 0", o_pred_target); end
      checks++; if (o_br_cnt !== 4'h0) begin errors++; $display("FAIL rst_br_cnt got %0d want 0", o_br_cnt); end
      checks++; if (o_mispred_cnt !== 4'h0) begin errors++; $display("FAIL rst_mis_cnt got %0d want 0", o_mispred_cnt); end
      checks++; if (o_pred_ghr !== 6'h0) begin errors++; $display("FAIL rst_ghr got %h want 0", o_pred_ghr); end
      checks++; if (o_mispred !== 1'b0) begin errors++; $display("FAIL idle_mispred got %0b want 0", o_mispred); end
   endtask

`ifndef BR_PRED_GSHARE_EN
   task automatic test_cold_taken();
      upd_begin(32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 0);
      checks++; if (o_mispred !== 1'b1) begin errors++; $display("FAIL cold_mispred got %0b want 1", o_mispred); end
      checks++; if (o_redirect_pc !== 32'h80) begin errors++; $display("FAIL cold_redirect got %h want 80", o_redirect_pc); end
      upd_end();
      look(32'h100);
      checks++; if (o_pred_taken !== 1'b1) begin errors++; $display("FAIL cold_taken got %0b want 1", o_pred_taken); end
      checks++; if (o_pred_target !== 32'h80) begin errors++; $display("FAIL cold_target got %h want 80", o_pred_target); end
      checks++; if (o_br_cnt !== 4'd1 || o_mispred_cnt !== 4'd1) begin errors++; $display("FAIL cold_cnts got %0d/%0d want 1/1", o_br_cnt, o_mispred_cnt); end
   endtask

   task automatic test_hysteresis();
      upd_begin(32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 0);
      checks++; if (o_redirect_pc !== 32'h104) begin errors++; $display("FAIL hyst_redirect got %h want 104", o_redirect_pc); end
      upd_end();
      look(32'h100);
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL hyst_ctr01 got %0b want 0", o_pred_taken); end
      upd_begin(32'h100, 1'b1, 32'h80, 1'b0, 32'h80, 0);
      upd_end();
      upd_begin(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 0);
      checks++; if (o_mispred !== 1'b0) begin errors++; $display("FAIL hyst_nomis got %0b want 0", o_mispred); end
      upd_end();
      look(32'h100);
      checks++; if (o_pred_taken !== 1'b1) begin errors++; $display("FAIL hyst_ctr11 got %0b want 1", o_pred_taken); end
      upd_begin(32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 0);
      upd_end();
      look(32'h100);
      checks++; if (o_pred_taken !== 1'b1) begin errors++; $display("FAIL hyst_ctr10 got %0b want 1", o_pred_taken); end
   endtask

   task automatic test_alias();
      look(32'h200);
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL alias_lookup got %0b want 0", o_pred_taken); end
      upd_begin(32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 0);
      checks++; if (o_redirect_pc !== 32'h204) begin errors++; $display("FAIL alias_redirect got %h want 204", o_redirect_pc); end
      upd_end();
      look(32'h100);
      checks++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h80) begin errors++; $display("FAIL alias_keep got %0b/%h want 1/80", o_pred_taken, o_pred_target); end
   endtask

   task automatic test_target_mispred();
      upd_begin(32'h300, 1'b1, 32'h400, 1'b0, 32'h0, 0);
      upd_end();
      upd_begin(32'h300, 1'b1, 32'h500, 1'b1, 32'h400, 0);
      checks++; if (o_mispred !== 1'b1) begin errors++; $display("FAIL tgt_mispred got %0b want 1", o_mispred); end
      checks++; if (o_redirect_pc !== 32'h500) begin errors++; $display("FAIL tgt_redirect got %h want 500", o_redirect_pc); end
      upd_end();
      look(32'h300);
      checks++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h500) begin errors++; $display("FAIL tgt_entry got %0b/%h want 1/500", o_pred_taken, o_pred_target); end
      upd_begin(32'h304, 1'b0, 32'h0, 1'b0, 32'h0, 0);
      checks++; if (o_mispred !== 1'b0 || o_redirect_pc !== 32'h308) begin errors++; $display("FAIL nt_redirect got %0b/%h want 0/308", o_mispred, o_redirect_pc); end
      upd_end();
      upd_begin(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 0);
      checks++; if (o_redirect_pc !== 32'h0) begin errors++; $display("FAIL wrap_redirect got %h want 0", o_redirect_pc); end
      upd_end();
   endtask
`else
   task automatic test_gshare();
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         upd_begin(32'h100, 1'b1, 32'h80, 1'b0, 32'h0, m_ghr);
         upd_end();
      end
      look(32'h100);
      checks++; if (o_pred_ghr !== 6'b000111) begin errors++; $display("FAIL gs_ghr got %b want 000111", o_pred_ghr); end
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL gs_idx7 got %0b want 0", o_pred_taken); end
      look(32'h11C);
      checks++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h80) begin errors++; $display("FAIL gs_idx0 got %0b/%h want 1/80", o_pred_taken, o_pred_target); end
      upd_begin(32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 0);
      upd_end();
      look(32'h138);
      checks++; if (o_pred_ghr !== 6'b001110) begin errors++; $display("FAIL gs_ghr2 got %b want 001110", o_pred_ghr); end
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL gs_upd_hist got %0b want 0", o_pred_taken); end
   endtask
`endif

   task automatic test_counter_sat();
      int exp;
      apply_reset();
      for (int k = 0; k < 16; k++) begin
         upd_begin(32'h1000 + 32'(k * 4), 1'b0, 32'h0, 1'b0, 32'h0, m_ghr);
         upd_end();
         exp = (k + 1 > CMAX) ? CMAX : k + 1;
         checks++; if (o_br_cnt !== CNT_W'(exp)) begin errors++; $display("FAIL br_cnt_sat got %0d want %0d", o_br_cnt, exp); end
      end
      checks++; if (o_mispred_cnt !== 4'd0) begin errors++; $display("FAIL mis_cnt_idle got %0d want 0", o_mispred_cnt); end
      for (int k = 0; k < 17; k++) begin
         upd_begin(32'h2000, 1'b1, 32'h40, 1'b0, 32'h0, m_ghr);
         upd_end();
         exp = (k + 1 > CMAX) ? CMAX : k + 1;
         checks++; if (o_mispred_cnt !== CNT_W'(exp) || o_br_cnt !== 4'hF) begin errors++; $display("FAIL mis_cnt_sat got %0d/%0d want %0d/15", o_mispred_cnt, o_br_cnt, exp); end
      end
   endtask

   task automatic test_reset_wins();
      apply_reset();
      upd_begin(32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 0);
      upd_end();
      @(negedge i_clk);
      i_rst = 1'b1;
      upd_begin(32'h180, 1'b1, 32'h44, 1'b0, 32'h0, m_ghr);
      upd_end();
      i_rst = 1'b0;
      look(32'h180);
      checks++; if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h0) begin errors++; $display("FAIL rstwin_drop got %0b/%h want 0/0", o_pred_taken, o_pred_target); end
      look(32'h100);
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL rstwin_clear got %0b want 0", o_pred_taken); end
      checks++; if (o_br_cnt !== 4'd0 || o_pred_ghr !== 6'd0) begin errors++; $display("FAIL rstwin_state got %0d/%h want 0/0", o_br_cnt, o_pred_ghr); end
   endtask

   task automatic test_random();
      logic [31:0] pc, tg, ptg, lpc, etg;
      bit          tk, ptk, etk, emis;
      int          gh;
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         pc  = rand_pc();
         lpc = rand_pc();
         tk  = 1'($urandom_range(0, 1));
         tg  = (n % 4 == 0) ? ($urandom() & 32'hFFFF_FFFC) : (32'($urandom_range(0, 7)) << 4);
         ptk = ($urandom_range(0, 3) != 0) ? tk : !tk;
         ptg = ($urandom_range(0, 2) != 0) ? tg : (32'($urandom_range(0, 7)) << 4);
         gh  = (GS && $urandom_range(0, 3) != 0) ? m_ghr : int'($urandom_range(0, NENT - 1));
         if ($urandom_range(0, 4) == 0) begin
            @(negedge i_clk);
            look(lpc);
            checks++; if (o_mispred !== 1'b0) begin errors++; $display("FAIL rnd_idle_mis got %0b want 0", o_mispred); end
            @(posedge i_clk);
            #1;
         end else begin
            i_if_pc = lpc;
            upd_begin(pc, tk, tg, ptk, ptg, gh);
            etk  = m_pred_taken(lpc);
            etg  = m_pred_target(lpc);
            emis = m_mispred();
            checks++; if (o_pred_taken !== etk) begin errors++; $display("FAIL rnd_taken pc=%h got %0b want %0b", lpc, o_pred_taken, etk); end
            checks++; if (o_pred_target !== etg) begin errors++; $display("FAIL rnd_target pc=%h got %h want %h", lpc, o_pred_target, etg); end
            checks++; if (o_pred_ghr !== IDX_W'(m_ghr)) begin errors++; $display("FAIL rnd_ghr got %h want %h", o_pred_ghr, IDX_W'(m_ghr)); end
            checks++; if (o_mispred !== emis) begin errors++; $display("FAIL rnd_mispred got %0b want %0b", o_mispred, emis); end
            checks++; if (o_redirect_pc !== (tk ? tg : pc + 32'd4)) begin errors++; $display("FAIL rnd_redirect got %h want %h", o_redirect_pc, tk ? tg : pc + 32'd4); end
            upd_end();
            checks++; if (o_br_cnt !== CNT_W'(m_br) || o_mispred_cnt !== CNT_W'(m_mis)) begin errors++; $display("FAIL rnd_cnts got %0d/%0d want %0d/%0d", o_br_cnt, o_mispred_cnt, m_br, m_mis); end
         end
      end
   endtask

   initial begin
      i_rst             = 1'b0;
      i_if_pc           = '0;
      i_upd_vld         = 1'b0;
      i_upd_pc          = '0;
      i_upd_taken       = 1'b0;
      i_upd_target      = '0;
      i_upd_pred_taken  = 1'b0;
      i_upd_pred_target = '0;
      i_upd_ghr         = '0;
      m_reset();
      test_reset();
`ifndef BR_PRED_GSHARE_EN
      test_cold_taken();
      test_hysteresis();
      test_alias();
      test_target_mispred();
`else
      test_gshare();
`endif
      test_counter_sat();
      test_reset_wins();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
